// File: rtl/serial_add_seq_if.sv
// Operand/result handshake and full-adder cell connections for serial_add_seq.
// The slave modport is the sequencer; master is the operand source plus adder cell.
interface serial_add_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum_out;
   logic             carry_out;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   modport slave (
      input  start, abort, a_in, b_in, fa_sum, fa_cout,
      output busy, done, sum_out, carry_out, fa_a, fa_b, fa_cin
   );

   modport master (
      output start, abort, a_in, b_in, fa_sum, fa_cout,
      input  busy, done, sum_out, carry_out, fa_a, fa_b, fa_cin
   );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial addition sequencer: feeds operands LSB-first to an external full adder,
// carries between bit-times and reports {carry, sum} with a one-cycle done pulse.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               clear_n,
   serial_add_seq_if.slave    bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] psum_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] sum_out_r;
   logic             carry_out_r;
   logic             busy_s;
   logic             done_s;
   logic             fa_a_s;
   logic             fa_b_s;
   logic             fa_cin_s;

   // State register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and output decode; outputs depend on registered state only
   always_comb begin
      state_s  = state_r;
      busy_s   = 1'b0;
      done_s   = 1'b0;
      fa_a_s   = 1'b0;
      fa_b_s   = 1'b0;
      fa_cin_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_SHIFT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy_s   = 1'b1;
            fa_a_s   = a_r[0];
            fa_b_s   = b_r[0];
            fa_cin_s = carry_r;
            if (bus.abort) begin
               state_s = ST_IDLE;
            end else if (cnt_r == LAST_CNT) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            busy_s  = 1'b1;
            done_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Operand shift registers, carry, bit counter and result registers
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         a_r         <= '0;
         b_r         <= '0;
         psum_r      <= '0;
         carry_r     <= 1'b0;
         cnt_r       <= '0;
         sum_out_r   <= '0;
         carry_out_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  a_r     <= bus.a_in;
                  b_r     <= bus.b_in;
                  psum_r  <= '0;
                  carry_r <= 1'b0;
                  cnt_r   <= '0;
               end
            end
            ST_SHIFT: begin
               // An abort leaves the result registers untouched
               if (!bus.abort) begin
                  a_r     <= a_r >> 1;
                  b_r     <= b_r >> 1;
                  psum_r  <= {bus.fa_sum, psum_r[WIDTH-1:1]};
                  carry_r <= bus.fa_cout;
                  cnt_r   <= cnt_r + 1'b1;
                  if (cnt_r == LAST_CNT) begin
                     sum_out_r   <= {bus.fa_sum, psum_r[WIDTH-1:1]};
                     carry_out_r <= bus.fa_cout;
                  end
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.busy      = busy_s;
   assign bus.done      = done_s;
   assign bus.sum_out   = sum_out_r;
   assign bus.carry_out = carry_out_r;
   assign bus.fa_a      = fa_a_s;
   assign bus.fa_b      = fa_b_s;
   assign bus.fa_cin    = fa_cin_s;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with WIDTH=8 and a behavioural full-adder cell.
module tb_serial_add_seq;

   logic clock;
   logic clear_n;
   int   checks;
   int   failures;

   serial_add_seq_if #(.WIDTH(8)) bus ();

   serial_add_seq #(.WIDTH(8)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
   assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Present start for one edge; returns in SHIFT cycle 1.
   task automatic go(input logic [7:0] a, input logic [7:0] b);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      clear_n   = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.a_in  = 8'h00;
      bus.b_in  = 8'h00;
      #20;
      checks++;
      if ({bus.busy, bus.done, bus.sum_out, bus.carry_out, bus.fa_a, bus.fa_b, bus.fa_cin} !== 14'h0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h c=%b fa=%b%b%b expected all 0",
                  bus.busy, bus.done, bus.sum_out, bus.carry_out, bus.fa_a, bus.fa_b, bus.fa_cin);
      end
      #2 clear_n = 1'b1;
      tick(2);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_basic();
      go(8'h5A, 8'h33);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_shift cycle %0d got busy=%b done=%b expected 1 0", c, bus.busy, bus.done);
         end
         tick(1);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.sum_out !== 8'h8D || bus.carry_out !== 1'b0) begin
         failures++;
         $display("FAIL basic_done got done=%b busy=%b sum=%h c=%b expected 1 1 8d 0",
                  bus.done, bus.busy, bus.sum_out, bus.carry_out);
      end
      tick(1);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum_out !== 8'h8D) begin
         failures++;
         $display("FAIL basic_after got done=%b busy=%b sum=%h expected 0 0 8d", bus.done, bus.busy, bus.sum_out);
      end
   endtask

   task automatic test_carry_chain();
      logic [7:0] a_v;
      a_v = 8'hFF;
      go(8'hFF, 8'h01);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (bus.fa_cin !== (c >= 2) || bus.fa_a !== a_v[c-1] || bus.fa_b !== (c == 1)) begin
            failures++;
            $display("FAIL carry_fa cycle %0d got a=%b b=%b cin=%b expected %b %b %b",
                     c, bus.fa_a, bus.fa_b, bus.fa_cin, a_v[c-1], (c == 1), (c >= 2));
         end
         tick(1);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.sum_out !== 8'h00 || bus.carry_out !== 1'b1) begin
         failures++;
         $display("FAIL carry_result got done=%b sum=%h c=%b expected 1 00 1", bus.done, bus.sum_out, bus.carry_out);
      end
      checks++;
      if (bus.fa_a !== 1'b0 || bus.fa_b !== 1'b0 || bus.fa_cin !== 1'b0) begin
         failures++;
         $display("FAIL carry_fa_done got fa=%b%b%b expected 000", bus.fa_a, bus.fa_b, bus.fa_cin);
      end
      tick(1);
   endtask

   task automatic test_ignore_start();
      go(8'h10, 8'h20);
      tick(2);
      bus.start = 1'b1;
      bus.a_in  = 8'h01;
      bus.b_in  = 8'h01;
      tick(1);
      bus.start = 1'b0;
      tick(5);
      checks++;
      if (bus.done !== 1'b1 || bus.sum_out !== 8'h30 || bus.carry_out !== 1'b0) begin
         failures++;
         $display("FAIL ignore_shift got done=%b sum=%h c=%b expected 1 30 0", bus.done, bus.sum_out, bus.carry_out);
      end
      bus.start = 1'b1;
      tick(1);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL ignore_done got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
      tick(1);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL restart_accept got busy=%b expected 1", bus.busy);
      end
      tick(8);
      checks++;
      if (bus.done !== 1'b1 || bus.sum_out !== 8'h02 || bus.carry_out !== 1'b0) begin
         failures++;
         $display("FAIL restart_result got done=%b sum=%h c=%b expected 1 02 0", bus.done, bus.sum_out, bus.carry_out);
      end
      tick(1);
   endtask

   task automatic test_abort();
      int seen_done;
      go(8'h77, 8'h11);
      tick(3);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got busy=%b expected 0", bus.busy);
      end
      seen_done = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.done === 1'b1) seen_done++;
         tick(1);
      end
      checks++;
      if (seen_done != 0 || bus.sum_out !== 8'h02 || bus.carry_out !== 1'b0) begin
         failures++;
         $display("FAIL abort_hold got done_pulses=%0d sum=%h c=%b expected 0 02 0", seen_done, bus.sum_out, bus.carry_out);
      end
      bus.abort = 1'b1;
      go(8'h80, 8'h80);
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL start_beats_abort got busy=%b expected 1", bus.busy);
      end
      tick(8);
      checks++;
      if (bus.done !== 1'b1 || bus.sum_out !== 8'h00 || bus.carry_out !== 1'b1) begin
         failures++;
         $display("FAIL start_abort_result got done=%b sum=%h c=%b expected 1 00 1", bus.done, bus.sum_out, bus.carry_out);
      end
      tick(1);
   endtask

   task automatic test_async_reset();
      int seen_done;
      go(8'h3C, 8'h0F);
      tick(3);
      #2 clear_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.sum_out, bus.carry_out, bus.fa_a, bus.fa_b, bus.fa_cin} !== 14'h0) begin
         failures++;
         $display("FAIL async_reset got busy=%b done=%b sum=%h c=%b fa=%b%b%b expected all 0",
                  bus.busy, bus.done, bus.sum_out, bus.carry_out, bus.fa_a, bus.fa_b, bus.fa_cin);
      end
      tick(1);
      #3 clear_n = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         if (bus.done === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL async_no_done got done_pulses=%0d busy=%b expected 0 0", seen_done, bus.busy);
      end
      go(8'h3C, 8'h0F);
      tick(8);
      checks++;
      if (bus.done !== 1'b1 || bus.sum_out !== 8'h4B || bus.carry_out !== 1'b0) begin
         failures++;
         $display("FAIL async_rerun got done=%b sum=%h c=%b expected 1 4b 0", bus.done, bus.sum_out, bus.carry_out);
      end
      tick(1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_ignore_start();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
